wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 159 +++++++++++++++
 tb/tb_wb_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result select, load wait, write qualification, timeout
//
// Purpose: accepts one retiring instruction per cycle from MEM, selects ALU
// result or load data, and drives the register file write port one cycle later.
// Loads whose data is not ready wait in WAIT_MEM, stalling upstream, and are
// aborted (err set, no write) after MEM_TIMEOUT cycles.
// Writes to R0 and R7 are suppressed but still retire.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid, in_reg_write,         instruction from MEM stage
//   in_mem_read, in_rd, in_alu_result
//   mem_rdata, mem_ready            load data return
//   stall_out                       upstream hold (combinational)
//   RegWrite, RDo, Mem_to_Reg       register file write port (registered)
//   retire_cnt                      retired-instruction counter (wraps)
//   err                             sticky load-timeout flag
//   byp_ra, byp_rb, byp_a_hit,      forwarding compare, only with WB_BYPASS_EN
//   byp_b_hit
//
// Optional feature macro: WB_BYPASS_EN
module wb_stage #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_out,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RDo,
  output logic [DATA_W-1:0] Mem_to_Reg,
  output logic [7:0]        retire_cnt,
  output logic              err
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_ra,
  input  logic [ADDR_W-1:0] byp_rb,
  output logic              byp_a_hit,
  output logic              byp_b_hit
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t              state_q, state_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [ADDR_W-1:0]   lrd_q, lrd_d;
  logic                lrw_q, lrw_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   rdo_q, rdo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          retire_q, retire_d;
  logic                err_q, err_d;

  // R0 and R7 are hardwired; writes to them retire without a write pulse.
  function automatic logic qualify(input logic rw, input logic [ADDR_W-1:0] rd);
    return rw && (rd != '0) && (rd != ADDR_W'(7));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      lrd_q    <= '0;
      lrw_q    <= 1'b0;
      we_q     <= 1'b0;
      rdo_q    <= '0;
      data_q   <= '0;
      retire_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      lrd_q    <= lrd_d;
      lrw_q    <= lrw_d;
      we_q     <= we_d;
      rdo_q    <= rdo_d;
      data_q   <= data_d;
      retire_q <= retire_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    lrd_d     = lrd_q;
    lrw_d     = lrw_q;
    we_d      = 1'b0;      // write enable is a one-cycle pulse
    rdo_d     = rdo_q;
    data_d    = data_q;
    retire_d  = retire_q;
    err_d     = err_q;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_mem_read) begin
            we_d     = qualify(in_reg_write, in_rd);
            rdo_d    = in_rd;
            data_d   = in_alu_result;
            retire_d = retire_q + 8'd1;
          end else if (mem_ready) begin
            we_d     = qualify(in_reg_write, in_rd);
            rdo_d    = in_rd;
            data_d   = mem_rdata;
            retire_d = retire_q + 8'd1;
          end else begin
            stall_out = 1'b1;
            lrd_d     = in_rd;
            lrw_d     = in_reg_write;
            tmo_d     = '0;
            state_d   = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        stall_out = 1'b1;
        if (mem_ready) begin
          // Data arriving on the expiry cycle still wins over the abort.
          we_d     = qualify(lrw_q, lrd_q);
          rdo_d    = lrd_q;
          data_d   = mem_rdata;
          retire_d = retire_q + 8'd1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'(MEM_TIMEOUT - 1)) begin
            err_d    = 1'b1;
            retire_d = retire_q + 8'd1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RegWrite   = we_q;
  assign RDo        = rdo_q;
  assign Mem_to_Reg = data_q;
  assign retire_cnt = retire_q;
  assign err        = err_q;

`ifdef WB_BYPASS_EN
  // RegWrite is never issued for R0/R7, so no extra exclusion is needed here.
  assign byp_a_hit = we_q && (rdo_q == byp_ra);
  assign byp_b_hit = we_q && (rdo_q == byp_rb);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard testbench for wb_stage
module tb_wb_stage;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_reg_write, in_mem_read;
  logic [2:0] in_rd;
  logic [7:0] in_alu_result, mem_rdata;
  logic       mem_ready;
  logic       stall_out, RegWrite;
  logic [2:0] RDo;
  logic [7:0] Mem_to_Reg, retire_cnt;
  logic       err;
`ifdef WB_BYPASS_EN
  logic [2:0] byp_ra = 3'd0, byp_rb = 3'd0;
  logic       byp_a_hit, byp_b_hit;
`endif

  wb_stage #(.DATA_W(8), .ADDR_W(3), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_rd(in_rd), .in_alu_result(in_alu_result),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_out(stall_out), .RegWrite(RegWrite), .RDo(RDo), .Mem_to_Reg(Mem_to_Reg),
    .retire_cnt(retire_cnt), .err(err)
`ifdef WB_BYPASS_EN
    , .byp_ra(byp_ra), .byp_rb(byp_rb), .byp_a_hit(byp_a_hit), .byp_b_hit(byp_b_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic       chk;   // RDo/Mem_to_Reg updated (not an aborted load)
    logic [2:0] rd;
    logic [7:0] data;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_retire = 8'd0;
  logic       exp_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one retired instruction per call.
  task automatic push_exp(input logic rw, input logic [2:0] rd, input logic [7:0] data,
                          input logic timed_out);
    exp_t e;
    exp_retire = exp_retire + 8'd1;
    if (timed_out) exp_err = 1'b1;
    e.wen  = !timed_out && rw && rd != 3'd0 && rd != 3'd7;
    e.chk  = !timed_out;
    e.rd   = rd;
    e.data = data;
    e.err  = exp_err;
    e.cnt  = exp_retire;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_reg_write  = 1'($urandom);
    in_mem_read   = 1'($urandom);
    in_rd         = 3'($urandom);
    in_alu_result = 8'($urandom);
    mem_rdata     = 8'($urandom);
    mem_ready     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_alu(input logic rw, input logic [2:0] rd, input logic [7:0] alu);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_read   = 1'b0;
    in_rd         = rd;
    in_alu_result = alu;
    mem_ready     = 1'($urandom);
    mem_rdata     = 8'($urandom);
    push_exp(rw, rd, alu, 1'b0);
    @(negedge clk);
    check("stall_alu", stall_out, 0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Load whose data arrives d cycles after acceptance; d > TO never arrives in time.
  task automatic issue_load(input logic rw, input logic [2:0] rd, input int d,
                            input logic [7:0] data);
    int last;
    last = (d > TO) ? TO : d;
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_read   = 1'b1;
    in_rd         = rd;
    in_alu_result = 8'($urandom);
    push_exp(rw, rd, data, d > TO);
    for (int k = 0; k <= last; k++) begin
      mem_ready = (k == d);
      mem_rdata = (k == d) ? data : 8'($urandom);
      @(negedge clk);
      check("stall_load", stall_out, (k > 0 || d != 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Monitor: every retire_cnt step consumes one expected entry.
  logic [7:0] prev_cnt = 8'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cnt = retire_cnt;
      end else if (retire_cnt != prev_cnt) begin
        prev_cnt = retire_cnt;
        if (sb.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("retire_cnt", retire_cnt, e.cnt);
          check("RegWrite", RegWrite, e.wen);
          check("err", err, e.err);
          if (e.chk) begin
            check("RDo", RDo, e.rd);
            check("Mem_to_Reg", Mem_to_Reg, e.data);
          end
        end
      end else if (RegWrite) begin
        check("RegWrite_no_retire", RegWrite, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_RegWrite", RegWrite, 0);
    check("rst_RDo", RDo, 0);
    check("rst_Mem_to_Reg", Mem_to_Reg, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue_alu(1'b1, 3'd3, 8'h5A);
    idle_cycles(2);
    issue_alu(1'b1, 3'd0, 8'h11);
    issue_alu(1'b1, 3'd7, 8'h22);
    issue_load(1'b1, 3'd5, 3, 8'hC3);
    idle_cycles(1);
    issue_load(1'b1, 3'd4, 0, 8'h3C);
    issue_load(1'b1, 3'd6, TO, 8'h77);     // data on expiry cycle wins
    issue_load(1'b1, 3'd2, TO + 5, 8'h99); // timeout
    issue_alu(1'b1, 3'd1, 8'hA5);
    idle_cycles(2);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int kind, d;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) idle_cycles(int'($urandom_range(1, 2)));
      else if (kind < 6) issue_alu(1'($urandom), 3'($urandom), 8'($urandom));
      else begin
        d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
        issue_load(1'($urandom), 3'($urandom), d, 8'($urandom));
      end
    end
    idle_cycles(3);

    // Asynchronous reset in the middle of a load wait
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_read = 1'b1; in_rd = 3'd5; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("arst_RegWrite", RegWrite, 0);
    check("arst_stall", stall_out, 0);
    check("arst_retire_cnt", retire_cnt, 0);
    check("arst_err", err, 0);
    check("arst_sb_empty", sb.size(), 0);
    sb.delete();
    exp_retire = 8'd0;
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    check("post_rst_stall", stall_out, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post_rst_RegWrite", RegWrite, 0);
    check("post_rst_retire", retire_cnt, 0);
    @(posedge clk); #1;
    issue_alu(1'b1, 3'd3, 8'h5A);
    idle_cycles(2);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
